uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one `UART_TX` transmitter among `NUM_REQ` byte producers. Each producer can optionally lock the transmitter for a multi-byte packet. The block owns the transmitter's `i_start`/`i_data` inputs and paces bytes on the transmitter's `o_TX_Done` pulse. A watchdog recovers from a stalled transmitter or an abandoned packet lock. It sits between the UART_TX instance and its producers (command responder, status reporter, debug echo).

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, 434: must match the UART_TX instance; used only to size the watchdog.
- `TIMEOUT_CYCLES`, 12*CLKS_PER_BIT: watchdog limit in WAIT_DONE and HOLD; must be greater than 10*CLKS_PER_BIT+2.
- `i_Clock`  in  1  system clock; one clock domain, all logic on the rising edge.
- `i_enable`  in  1  reset; asynchronous, active-low.
- `i_req_valid`  in  NUM_REQ  per-requester byte available; held high until ack.
- `i_req_data`  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- `i_req_last`  in  NUM_REQ  byte is the final byte of its packet; single-byte sends tie this high.
- `o_req_ack`  out  NUM_REQ  one-cycle pulse: byte of requester i captured.
- `o_tx_start`  out  1  one-cycle start pulse to UART_TX `i_start`.
- `o_tx_data`  out  8  byte to UART_TX `i_data`; held stable from start until done.
- `i_tx_done`  in  1  UART_TX `o_TX_Done`.
- `o_grant`  out  NUM_REQ  one-hot current owner; zero when free.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_timeout`  out  1  one-cycle pulse on watchdog expiry.
- `o_timeout_id`  out  3  index of the owner at expiry; held until the next expiry.

## Operation
- States: IDLE, WAIT_DONE, HOLD.
- **IDLE**
  - On any `i_req_valid`, the round-robin pick is the first valid index at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - On that edge, register the grant, `o_tx_data`, `o_tx_start`=1 and `o_req_ack[pick]`=1.
  - Latch `lock = !i_req_last[pick]` and go to WAIT_DONE.
- **WAIT_DONE**
  - `o_tx_start` and `o_req_ack` drop after one cycle; the watchdog counts up.
  - On `i_tx_done`, clear the watchdog.
  - If `lock`=0: set `rr_ptr = owner+1` (mod NUM_REQ), clear the grant and go to IDLE.
  - If `lock`=1: go to HOLD.
- **HOLD** (packet in progress; other requesters are ignored)
  - On `i_req_valid[owner]`: capture, start and ack exactly as in IDLE, update `lock` from `i_req_last`, and go to WAIT_DONE.
- **Watchdog expiry** (count reaches TIMEOUT_CYCLES-1 in WAIT_DONE or HOLD)
  - Pulse `o_timeout`, load `o_timeout_id` = owner, clear `lock` and the grant.
  - Advance `rr_ptr` past the owner and go to IDLE.
- **Done outside WAIT_DONE:** `i_tx_done` in IDLE or HOLD is ignored.
- **Simultaneous events:** `i_tx_done` on the expiry cycle counts as done; no timeout is raised.
- **Single requester:** with only one valid requester, that requester is picked regardless of `rr_ptr`.
- **Reset mid-operation:** asserting `i_enable` low at any point forces the following immediately and asynchronously:
  - all outputs 0, `o_timeout_id`=0, `rr_ptr`=0, `lock`=0, watchdog 0, state IDLE.
  - Any byte in flight is abandoned; UART_TX is expected to share the same reset.

## Timing
- Request to start:
  - IDLE: `i_req_valid` high before edge k gives `o_tx_start`, `o_req_ack` and the new `o_tx_data`/`o_grant` valid during cycle k+1.
  - HOLD: same one-cycle latency.
- Done to next start:
  - `i_tx_done` at edge d puts the block in IDLE or HOLD at d.
  - The earliest next start pulse is at d+1, which UART_TX, back in IDLE, samples at d+2.
- Throughput: one byte per UART frame plus 2 cycles.
- Requesters may change `i_req_data`/`i_req_valid` in the cycle after ack.
- Watchdog width: $clog2(TIMEOUT_CYCLES).

## Structure
- Shared package `uart_pkg`: state encodings (IDLE=2'b00, WAIT_DONE=2'b01, HOLD=2'b10) and the `TIMEOUT_CYCLES` default formula. UART_TX state constants move there too.
- One sub-module `rr_pick`:
  - inputs: `NUM_REQ`-bit request vector and pointer.
  - output: one-hot pick plus index.
  - purely combinational, reused by future RX-side arbitration.
- The FSM, `rr_ptr`, `lock` and the watchdog stay in `uart_tx_arbiter`.

## Test plan
- **Single byte:** req0 valid, data 0x55, last=1 at cycle 10 -> start and ack[0] in cycle 11, `o_tx_data`=0x55, `o_grant`=0001; done 4340 cycles later -> `o_busy`=0 next cycle.
- **Round-robin:** all four valid, last=1, after reset -> grant order 0,1,2,3,0. Each start comes 1 cycle after the previous done.
- **Packet lock:** req1 sends 3 bytes (A1,A2,A3; last on A3) while req2 stays valid -> sequence A1,A2,A3, then req2's byte.
- **TX stall:** send with `i_tx_done` never asserted -> `o_timeout` pulses at cycle TIMEOUT_CYCLES after start, `o_timeout_id`=owner, next requester served.
- **Abandoned lock:** req3 sends last=0 then drops valid -> timeout in HOLD, id=3, req0 served afterwards.
- **Reset mid-frame:** assert `i_enable`=0 during WAIT_DONE -> all outputs 0 within the same cycle; after release, req2 alone valid is picked first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter and transmitter state encodings plus
// small timing/index helpers used across the TX path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_DONE = 2'b01,
        HOLD      = 2'b10
    } arb_state_t;

    typedef enum logic [2:0] {
        TX_IDLE      = 3'b000,
        TX_START_BIT = 3'b001,
        TX_DATA_BITS = 3'b010,
        TX_STOP_BIT  = 3'b011,
        TX_CLEANUP   = 3'b100
    } tx_state_t;

    // A full 10-bit frame plus two bit-times of slack before the watchdog fires.
    function automatic int timeout_cycles(input int clks_per_bit);
        return 12 * clks_per_bit;
    endfunction

    function automatic int wrap_inc(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ. Shared by TX and future RX arbitration.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               pick_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        pick_valid  = 1'b0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'(wrap_inc(int'(ptr), i, NUM_REQ));
            if (!pick_valid && req[cand]) begin
                pick_valid        = 1'b1;
                pick_idx          = cand;
                pick_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers,
// with per-producer packet lock and a watchdog for stalls and abandoned locks.
//
// state     | meaning
// IDLE      | transmitter free, waiting for any request
// WAIT_DONE | byte handed to UART_TX, waiting for its done pulse
// HOLD      | packet lock held, only the owner may send the next byte
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int CLKS_PER_BIT   = 434,
    parameter int TIMEOUT_CYCLES = timeout_cycles(CLKS_PER_BIT)
) (
    input  logic                 i_Clock,
    input  logic                 i_enable,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ack,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_done,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_busy,
    output logic                 o_timeout,
    output logic [2:0]           o_timeout_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    arb_state_t           state, state_nxt;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]     owner, owner_nxt, owner_next;
    logic                 lock, lock_nxt;
    logic [WD_W-1:0]      wd_cnt, wd_nxt;
    logic                 wd_expired;

    logic [NUM_REQ-1:0]   ack_nxt, grant_nxt, pick_onehot, sel_onehot;
    logic                 start_nxt, timeout_nxt, pick_valid;
    logic [7:0]           data_nxt, sel_data;
    logic [2:0]           tid_nxt;
    logic [IDX_W-1:0]     pick_idx, load_idx;
    logic                 sel_last, load, expire;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .req         (i_req_valid),
        .ptr         (rr_ptr),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_valid  (pick_valid)
    );

    // In HOLD only the current owner may be captured; otherwise the rr pick.
    assign load_idx   = (state == HOLD) ? owner : pick_idx;
    assign sel_onehot = (state == HOLD) ? (NUM_REQ'(1) << owner) : pick_onehot;
    assign owner_next = IDX_W'(wrap_inc(int'(owner), 1, NUM_REQ));
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign o_busy     = (state != IDLE);

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (load_idx == IDX_W'(i)) begin
                sel_data = i_req_data[8*i +: 8];
                sel_last = i_req_last[i];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        owner_nxt   = owner;
        lock_nxt    = lock;
        wd_nxt      = wd_cnt;
        grant_nxt   = o_grant;
        data_nxt    = o_tx_data;
        tid_nxt     = o_timeout_id;
        ack_nxt     = '0;
        start_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        load        = 1'b0;
        expire      = 1'b0;

        case (state)
            IDLE: load = pick_valid;
            WAIT_DONE: begin
                // A done on the expiry cycle still counts as a completed byte.
                if (i_tx_done) begin
                    wd_nxt = '0;
                    if (lock) begin
                        state_nxt = HOLD;
                    end else begin
                        rr_ptr_nxt = owner_next;
                        grant_nxt  = '0;
                        state_nxt  = IDLE;
                    end
                end else if (wd_expired) begin
                    expire = 1'b1;
                end else begin
                    wd_nxt = wd_cnt + WD_W'(1);
                end
            end
            HOLD: begin
                if (i_req_valid[owner]) begin
                    load = 1'b1;
                end else if (wd_expired) begin
                    expire = 1'b1;
                end else begin
                    wd_nxt = wd_cnt + WD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            owner_nxt = load_idx;
            grant_nxt = sel_onehot;
            ack_nxt   = sel_onehot;
            data_nxt  = sel_data;
            start_nxt = 1'b1;
            lock_nxt  = !sel_last;
            wd_nxt    = '0;
            state_nxt = WAIT_DONE;
        end

        if (expire) begin
            timeout_nxt = 1'b1;
            tid_nxt     = 3'(owner);
            lock_nxt    = 1'b0;
            grant_nxt   = '0;
            rr_ptr_nxt  = owner_next;
            wd_nxt      = '0;
            state_nxt   = IDLE;
        end
    end

    always_ff @(posedge i_Clock or negedge i_enable) begin
        if (!i_enable) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            lock         <= 1'b0;
            wd_cnt       <= '0;
            o_req_ack    <= '0;
            o_tx_start   <= 1'b0;
            o_tx_data    <= '0;
            o_grant      <= '0;
            o_timeout    <= 1'b0;
            o_timeout_id <= '0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            owner        <= owner_nxt;
            lock         <= lock_nxt;
            wd_cnt       <= wd_nxt;
            o_req_ack    <= ack_nxt;
            o_tx_start   <= start_nxt;
            o_tx_data    <= data_nxt;
            o_grant      <= grant_nxt;
            o_timeout    <= timeout_nxt;
            o_timeout_id <= tid_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with literal expectations plus
// randomized producers/transmitter checked every cycle against a transaction model.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int CPB = 16;
    localparam int T   = 12 * CPB;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_last = '0;
    logic [8*NR-1:0] req_data = '0;
    logic            tx_done = 1'b0;
    logic [NR-1:0]   req_ack, grant;
    logic            tx_start, busy, tmo;
    logic [7:0]      tx_data;
    logic [2:0]      tmo_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(T)) dut (
        .i_Clock      (clk),
        .i_enable     (rst_n),
        .i_req_valid  (req_valid),
        .i_req_data   (req_data),
        .i_req_last   (req_last),
        .o_req_ack    (req_ack),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .i_tx_done    (tx_done),
        .o_grant      (grant),
        .o_busy       (busy),
        .o_timeout    (tmo),
        .o_timeout_id (tmo_id)
    );

    int n_vec = 0;
    int n_err = 0;
    bit auto_run = 1'b0;
    int tx_cnt = 0;
    int cool [NR];

    // Transaction-level model: who owns the transmitter, whether a byte is
    // in flight, and how long since the last start/done.
    int            m_owner = -1;
    bit            m_inflight = 1'b0;
    bit            m_lock = 1'b0;
    int            m_ptr = 0;
    int            m_age = 0;
    logic [NR-1:0] e_ack = '0, e_grant = '0;
    logic          e_start = 1'b0, e_busy = 1'b0, e_to = 1'b0;
    logic [7:0]    e_data = '0;
    logic [2:0]    e_tid = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_owner = -1; m_inflight = 1'b0; m_lock = 1'b0; m_ptr = 0; m_age = 0;
            e_ack = '0; e_start = 1'b0; e_to = 1'b0; e_data = '0; e_tid = '0;
        end else begin : step
            int pick;
            bit expire;
            pick = -1; expire = 1'b0;
            e_ack = '0; e_start = 1'b0; e_to = 1'b0;
            if (m_owner < 0) begin
                for (int j = 0; j < NR; j++)
                    if (pick < 0 && req_valid[(m_ptr + j) % NR]) pick = (m_ptr + j) % NR;
            end else if (m_inflight) begin
                if (tx_done) begin
                    m_inflight = 1'b0; m_age = 0;
                    if (!m_lock) begin m_ptr = (m_owner + 1) % NR; m_owner = -1; end
                end else if (m_age == T - 1) expire = 1'b1;
                else m_age++;
            end else begin
                if (req_valid[m_owner]) pick = m_owner;
                else if (m_age == T - 1) expire = 1'b1;
                else m_age++;
            end
            if (expire) begin
                e_to = 1'b1; e_tid = 3'(m_owner);
                m_ptr = (m_owner + 1) % NR; m_owner = -1; m_lock = 1'b0; m_inflight = 1'b0;
            end
            if (pick >= 0) begin
                m_owner = pick; m_inflight = 1'b1; m_lock = !req_last[pick]; m_age = 0;
                e_start = 1'b1; e_ack = NR'(1) << pick; e_data = req_data[8*pick +: 8];
            end
        end
        e_grant = (m_owner >= 0) ? NR'(1) << m_owner : '0;
        e_busy  = (m_owner >= 0);
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            n_vec++;
            if ({req_ack, tx_start, tx_data, grant, busy, tmo, tmo_id} !==
                {e_ack, e_start, e_data, e_grant, e_busy, e_to, e_tid}) begin
                n_err++;
                $display("FAIL model_cmp t=%0t: got ack=%b start=%b data=%h grant=%b busy=%b to=%b id=%0d, expected ack=%b start=%b data=%h grant=%b busy=%b to=%b id=%0d",
                         $time, req_ack, tx_start, tx_data, grant, busy, tmo, tmo_id,
                         e_ack, e_start, e_data, e_grant, e_busy, e_to, e_tid);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic auto_step();
        tx_done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_done = 1'b1;
        end else if ($urandom_range(63) == 0) begin
            tx_done = 1'b1;
        end
        if (tx_start) tx_cnt = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(10*CPB + 2, 1));
        for (int i = 0; i < NR; i++) begin
            if (req_ack[i]) begin
                req_valid[i] = 1'b0;
                cool[i] = (!req_last[i] && $urandom_range(5) == 0) ? T + 8 : int'($urandom_range(6));
            end else if (!req_valid[i]) begin
                if (cool[i] > 0) cool[i]--;
                else if ($urandom_range(3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_last[i] = ($urandom_range(2) != 0);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (auto_run) auto_step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic serve(input int idx, input logic [7:0] d, input string tag, output int lat);
        lat = 0;
        tick();
        while (!tx_start && lat < 4 * T) begin tick(); lat++; end
        check({tag, "_start"}, 32'(tx_start), 1);
        check({tag, "_grant"}, 32'(grant), 32'(1) << idx);
        check({tag, "_ack"}, 32'(req_ack), 32'(1) << idx);
        check({tag, "_data"}, 32'(tx_data), 32'(d));
    endtask

    task automatic finish_byte(input int gap);
        repeat (gap) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_timeout(output int n);
        n = 0;
        while (!tmo && n < 3 * T) begin tick(); n++; end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit reached at %0t", $time);
        $fatal(1, "time limit");
    end

    initial begin
        int lat, n;
        int rr_order [5] = '{0, 1, 2, 3, 0};

        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_data", 32'(tx_data), 0);
        check("rst_tid", 32'(tmo_id), 0);

        req_valid[0] = 1'b1; req_data[7:0] = 8'h55; req_last[0] = 1'b1;
        serve(0, 8'h55, "single", lat);
        check("single_lat", 32'(lat), 0);
        req_valid[0] = 1'b0;
        repeat (10 * CPB) tick();
        check("single_busy_mid", 32'(busy), 1);
        finish_byte(0);
        check("single_busy_end", 32'(busy), 0);
        check("single_grant_end", 32'(grant), 0);

        do_reset();
        req_valid = '1; req_last = '1;
        for (int i = 0; i < NR; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
        for (int k = 0; k < 5; k++) begin
            serve(rr_order[k], 8'(8'h10 + rr_order[k]), "rr", lat);
            check("rr_lat", 32'(lat), 0);
            finish_byte(3);
        end
        req_valid = '0;

        do_reset();
        req_valid[1] = 1'b1; req_data[15:8] = 8'hA1; req_last[1] = 1'b0;
        req_valid[2] = 1'b1; req_data[23:16] = 8'hB2; req_last[2] = 1'b1;
        serve(1, 8'hA1, "pkt1", lat);
        req_data[15:8] = 8'hA2;
        finish_byte(4);
        serve(1, 8'hA2, "pkt2", lat);
        check("pkt2_lat", 32'(lat), 0);
        req_data[15:8] = 8'hA3; req_last[1] = 1'b1;
        finish_byte(4);
        serve(1, 8'hA3, "pkt3", lat);
        req_valid[1] = 1'b0;
        finish_byte(4);
        serve(2, 8'hB2, "pkt_next", lat);
        req_valid[2] = 1'b0;
        finish_byte(4);

        do_reset();
        req_valid[1] = 1'b1; req_data[15:8] = 8'h22; req_last[1] = 1'b1;
        req_valid[2] = 1'b1; req_data[23:16] = 8'h33; req_last[2] = 1'b1;
        serve(1, 8'h22, "stall", lat);
        req_valid[1] = 1'b0;
        wait_timeout(n);
        check("stall_cycles", 32'(n), T);
        check("stall_tid", 32'(tmo_id), 1);
        check("stall_busy", 32'(busy), 0);
        serve(2, 8'h33, "stall_next", lat);
        check("stall_next_lat", 32'(lat), 0);
        req_valid[2] = 1'b0;
        finish_byte(4);

        do_reset();
        req_valid[3] = 1'b1; req_data[31:24] = 8'h3C; req_last[3] = 1'b0;
        serve(3, 8'h3C, "abandon", lat);
        req_valid[3] = 1'b0;
        finish_byte(4);
        req_valid[0] = 1'b1; req_data[7:0] = 8'h44; req_last[0] = 1'b1;
        repeat (10) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_timeout(n);
        check("abandon_cycles", 32'(n), T - 11);
        check("abandon_tid", 32'(tmo_id), 3);
        serve(0, 8'h44, "abandon_next", lat);
        check("abandon_next_lat", 32'(lat), 0);
        req_valid[0] = 1'b0;
        finish_byte(4);

        do_reset();
        req_valid[1] = 1'b1; req_data[15:8] = 8'h5A; req_last[1] = 1'b0;
        serve(1, 8'h5A, "rstmid", lat);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_outs", 32'({req_ack, tx_start, tx_data, grant, busy, tmo, tmo_id}), 0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        req_valid[2] = 1'b1; req_data[23:16] = 8'h66; req_last[2] = 1'b1;
        rst_n = 1'b1;
        serve(2, 8'h66, "rstmid_next", lat);
        check("rstmid_next_lat", 32'(lat), 0);
        req_valid[2] = 1'b0;
        finish_byte(4);

        do_reset();
        for (int i = 0; i < NR; i++) cool[i] = 0;
        tx_cnt = 0;
        auto_run = 1'b1;
        repeat (30000) tick();
        auto_run = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
